// File: rtl/zbt_disp_reader.sv
// zbt_disp_reader: display-side reader for ZBT bank 1. Turns the VGA raster position
// into lookahead read addresses, waits out the ZBT read latency, holds each two-pixel
// word while its two pixels are on screen, and registers one RGB888 pixel per clock
// together with the timing-generator syncs so everything leaves aligned.
// Read timing: an address launched at a clock edge has its word on zbt_read_data
// during the (READ_LAT-1)-th cycle after the cycle in which it first appears.
// That word is then captured at the end of that cycle.

module zbt_disp_reader #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned H_TOTAL  = 1344,
  parameter int unsigned V_TOTAL  = 806,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [35:0] zbt_read_data,
  output logic [18:0] zbt_read_addr,
  output logic        zbt_read_en,
  output logic [23:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank,
  output logic        pix_valid
);

  // Fetch this far ahead so the word is already captured when its pair reaches the screen.
  localparam int unsigned LOOKAHEAD = READ_LAT + 1;

  logic [11:0]         fetch_h;
  logic [10:0]         fetch_v;
  logic [18:0]         addr_d, addr_q;
  logic [READ_LAT-1:0] tag_d, tag_q;
  logic [35:0]         word_d, word_q;
  logic [17:0]         pixel;
  logic                active;
  logic [23:0]         rgb_d, rgb_q;
  logic                valid_d, valid_q;
  logic                hsync_d, hsync_q;
  logic                vsync_d, vsync_q;
  logic                blank_d, blank_q;

  // Project the raster position forward, wrapping line and frame, and decide whether to read.
  always_comb begin
    fetch_h = {1'b0, hcount} + 12'(LOOKAHEAD);
    fetch_v = {1'b0, vcount};
    if (fetch_h >= 12'(H_TOTAL)) begin
      fetch_h = fetch_h - 12'(H_TOTAL);
      fetch_v = fetch_v + 11'd1;
    end
    if (fetch_v == 11'(V_TOTAL)) begin
      fetch_v = '0;
    end
    addr_d = {fetch_v[9:0], fetch_h[9:1]};
    tag_d  = '0;
    tag_d[0] = ~fetch_h[0] && (fetch_h < 12'(H_ACTIVE)) && (fetch_v < 11'(V_ACTIVE));
    for (int i = 1; i < int'(READ_LAT); i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Capture the returning word only when the tag says a real read lands this cycle.
  always_comb begin
    word_d = word_q;
    if (tag_q[READ_LAT-1]) begin
      word_d = zbt_read_data;
    end
  end

  // Pick the half of the held word for this column and widen each 6-bit channel to 8 bits.
  always_comb begin
    pixel   = hcount[0] ? word_q[17:0] : word_q[35:18];
    active  = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    rgb_d   = '0;
    if (active) begin
      rgb_d = {pixel[17:12], pixel[17:16],
               pixel[11:6],  pixel[11:10],
               pixel[5:0],   pixel[5:4]};
    end
    valid_d = active;
    hsync_d = hsync;
    vsync_d = vsync;
    blank_d = blank;
  end

  // All pipeline state; reset parks the outputs at black/blanked with no read pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      tag_q   <= '0;
      word_q  <= '0;
      rgb_q   <= '0;
      valid_q <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
    end
  end

  assign zbt_read_addr = addr_q;
  assign zbt_read_en   = tag_q[0];
  assign vga_rgb       = rgb_q;
  assign pix_valid     = valid_q;
  assign vga_hsync     = hsync_q;
  assign vga_vsync     = vsync_q;
  assign vga_blank     = blank_q;

endmodule

// File: tb/tb_zbt_disp_reader.sv
// Bench for zbt_disp_reader: two instances (READ_LAT 2 and 3) share one raster stimulus.
// Each has its own ZBT model; expected outputs are queued at stimulus time and a monitor
// pops and compares them after every clock edge.

module tb_zbt_disp_reader;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int H_TOTAL  = 1344;
  localparam int V_TOTAL  = 806;

  typedef struct {
    logic        chk_pix;
    logic [23:0] rgb;
    logic        pv;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        en;
    logic [18:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;

  logic [35:0] rd_a, rd_b;
  logic [18:0] addr_a, addr_b;
  logic        en_a, en_b;
  logic [23:0] rgb_a, rgb_b;
  logic        hs_a, hs_b, vs_a, vs_b, bl_a, bl_b, pv_a, pv_b;

  logic [18:0] hist_a, hist_b0, hist_b1;
  logic [35:0] key;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seg_start = 0;
  bit seg_zero = 1'b0;
  bit hold_reset = 1'b1;
  int cur_h, cur_v;

  always #5 clk = ~clk;

  zbt_disp_reader #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL),
                    .V_TOTAL(V_TOTAL), .READ_LAT(2)) dut_a (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .zbt_read_data(rd_a),
    .zbt_read_addr(addr_a), .zbt_read_en(en_a), .vga_rgb(rgb_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_blank(bl_a), .pix_valid(pv_a));

  zbt_disp_reader #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL),
                    .V_TOTAL(V_TOTAL), .READ_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .zbt_read_data(rd_b),
    .zbt_read_addr(addr_b), .zbt_read_en(en_b), .vga_rgb(rgb_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank(bl_b), .pix_valid(pv_b));

  // Frame-buffer contents: a keyed scramble of the address, with one fixed colour word.
  function automatic logic [35:0] memWord(input logic [18:0] a, input logic [35:0] k);
    logic [35:0] w;
    w[35:18] = {a[8:0], a[18:10]} ^ k[17:0];
    w[17:0]  = a[17:0] ^ k[35:18];
    if (a == {10'd5, 9'd7}) w[35:18] = 18'b111111_000000_100000;
    return w;
  endfunction

  // ZBT model: the address register delayed READ_LAT-1 clocks selects the word.
  always @(posedge clk) begin
    hist_a  <= addr_a;
    hist_b0 <= addr_b;
    hist_b1 <= hist_b0;
  end
  always_comb rd_a = memWord(hist_a, key);
  always_comb rd_b = memWord(hist_b1, key);

  function automatic logic [7:0] ex(input logic [5:0] c);
    return {c, 2'b00} + 8'(c >> 4);
  endfunction

  // Reference: what each output should show one clock after (h,v) is presented.
  function automatic exp_t model(input int h, input int v, input logic hs_in,
                                 input logic vs_in, input logic bl_in, input int lk);
    exp_t e;
    int fh, fv, p, fc;
    logic [35:0] w;
    logic [17:0] px;
    fh = h + lk;
    fv = v;
    if (fh >= H_TOTAL) begin fh -= H_TOTAL; fv += 1; end
    if (fv == V_TOTAL) fv = 0;
    e.en   = (fh % 2 == 0) && (fh < H_ACTIVE) && (fv < V_ACTIVE);
    e.addr = 19'(fv * 512 + (fh / 2) % 512);
    e.hs = hs_in; e.vs = vs_in; e.bl = bl_in;
    e.chk_pix = 1'b1;
    e.rgb = 24'h0;
    e.pv  = 1'b0;
    if (h < H_ACTIVE && v < V_ACTIVE) begin
      e.pv = 1'b1;
      p  = h - (h % 2);
      fc = cyc - (h - p) - lk;
      if (fc >= seg_start) begin
        w  = memWord(19'(v * 512 + p / 2), key);
        px = (h % 2 == 1) ? w[17:0] : w[35:18];
        e.rgb = {ex(px[17:12]), ex(px[11:6]), ex(px[5:0])};
        if (v == 5 && h == 14) e.rgb = 24'hFF0082;
      end else if (!seg_zero) begin
        e.chk_pix = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input logic [23:0] rgb,
                             input logic pv, input logic hs, input logic vs, input logic bl,
                             input logic en, input logic [18:0] addr);
    checkVal({tag, ".en"}, 32'(en), 32'(e.en));
    checkVal({tag, ".addr"}, 32'(addr), 32'(e.addr));
    checkVal({tag, ".pix_valid"}, 32'(pv), 32'(e.pv));
    checkVal({tag, ".syncs"}, 32'({hs, vs, bl}), 32'({e.hs, e.vs, e.bl}));
    if (e.chk_pix) checkVal({tag, ".rgb"}, 32'(rgb), 32'(e.rgb));
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, ".A.addr"}, 32'(addr_a), 32'h0);
    checkVal({tag, ".A.en"}, 32'(en_a), 32'h0);
    checkVal({tag, ".A.rgb"}, 32'(rgb_a), 32'h0);
    checkVal({tag, ".A.flags"}, 32'({pv_a, hs_a, vs_a, bl_a}), 32'h1);
    checkVal({tag, ".B.addr"}, 32'(addr_b), 32'h0);
    checkVal({tag, ".B.en"}, 32'(en_b), 32'h0);
    checkVal({tag, ".B.rgb"}, 32'(rgb_b), 32'h0);
    checkVal({tag, ".B.flags"}, 32'({pv_b, hs_b, vs_b, bl_b}), 32'h1);
  endtask

  // Monitor: after every edge, compare whatever was scheduled for that edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      checkOutput("A", e, rgb_a, pv_a, hs_a, vs_a, bl_a, en_a, addr_a);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      checkOutput("B", e, rgb_b, pv_b, hs_b, vs_b, bl_b, en_b, addr_b);
    end
  end

  task automatic applyStimulus(input int h, input int v);
    logic hs_in, vs_in, bl_in;
    @(negedge clk);
    if (reset && !hold_reset) begin
      seg_start = cyc;
      seg_zero  = 1'b1;
    end
    reset  = hold_reset;
    hs_in  = (h >= 1048 && h < 1184);
    vs_in  = (v >= 771 && v < 777);
    bl_in  = !(h < H_ACTIVE && v < V_ACTIVE);
    hcount = 11'(h);
    vcount = 10'(v);
    hsync  = hs_in;
    vsync  = vs_in;
    blank  = bl_in;
    if (!reset) begin
      q_a.push_back(model(h, v, hs_in, vs_in, bl_in, 3));
      q_b.push_back(model(h, v, hs_in, vs_in, bl_in, 4));
    end
    cyc++;
  endtask

  task automatic runCycles(input int len);
    for (int i = 0; i < len; i++) begin
      applyStimulus(cur_h, cur_v);
      cur_h++;
      if (cur_h == H_TOTAL) begin
        cur_h = 0;
        cur_v++;
        if (cur_v == V_TOTAL) cur_v = 0;
      end
    end
  endtask

  task automatic runSegment(input int v0, input int h0, input int len);
    cur_h     = h0;
    cur_v     = v0;
    seg_start = cyc;
    seg_zero  = 1'b0;
    runCycles(len);
  endtask

  initial begin
    key    = {4'($urandom()), $urandom()};
    reset  = 1'b1;
    hcount = '0;
    vcount = '0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    blank  = 1'b0;
    #2;
    checkReset("reset_init");
    repeat (3) @(posedge clk);
    hold_reset = 1'b0;

    // Whole of line 5 with prefetch from line 4, including line wrap and blanking.
    runSegment(4, 1300, 1450);
    // Frame wrap and the last active line's wrap into blanking.
    runSegment(805, 1300, 80);
    runSegment(767, 1300, 80);

    // Reset asserted between edges mid-line, then released.
    runSegment(5, 470, 31);
    @(posedge clk);
    #3;
    hold_reset = 1'b1;
    reset = 1'b1;
    #1;
    checkReset("reset_mid");
    runCycles(4);
    hold_reset = 1'b0;
    runCycles(150);

    // Random jumps around the raster.
    for (int i = 0; i < 12; i++) begin
      runSegment(int'($urandom_range(0, V_TOTAL - 1)), int'($urandom_range(0, H_TOTAL - 1)),
                 int'($urandom_range(60, 400)));
    end

    @(posedge clk);
    #3;
    checkVal("queues_drained", 32'(q_a.size() + q_b.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
